// File: rtl/spi_slave_sync_pkg.sv
// spi_slave_sync_pkg: shared constants for the SPI slave front end
//   SPI_W     default word width
//   TX_FILL   word sent on MISO when the tx buffer is empty at word start
//   SPI_MODE0 {CPOL, CPHA} supported by this slave
package spi_pkg;
   localparam int SPI_W = 8;
   localparam logic [7:0] TX_FILL = 8'h00;
   localparam logic [1:0] SPI_MODE0 = 2'b00;
endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: raw SPI pin bundle
//   sck  SPI clock, master to slave
//   sdi  MOSI, master to slave
//   sdo  MISO, slave to master
//   nss  active-low slave select, master to slave
interface spi_slave_sync_if;
   logic sck;
   logic sdi;
   logic sdo;
   logic nss;
   modport slave (input sck, sdi, nss, output sdo);
   modport master (output sck, sdi, nss, input sdo);
endinterface

// File: rtl/spi_slave_sync_sync.sv
// spi_sync: N-stage input synchroniser with rise/fall pulses
//   clk, nreset  system clock, async active-low reset
//   d            raw asynchronous input
//   q            synchronised level
//   rise, fall   one-clk pulses on q edges
module spi_sync #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic nreset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   import spi_pkg::*;
   logic [N-1:0] chain;
   logic         prev;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         chain <= {N{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[N-2:0], d};
         prev  <= chain[N-1];
      end
   end
   assign q    = chain[N-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: clk-domain SPI mode-0 slave, MSB first, with one-word tx buffer
//   clk, nreset   system clock (>= 4x sck), async active-low reset
//   spi           raw SPI pins (slave modport)
//   rx_data       last complete received word, rx_valid pulses one clk on update
//   tx_data       word to send, written by tx_load while tx_ready is high
//   frame_active  synchronised nss is low
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = SPI_W
) (
   input  logic              clk,
   input  logic              nreset,
   spi_slave_sync_if.slave   spi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic              frame_active
);
   localparam int CW = $clog2(DATA_W);
   logic                   unused_sck_level;
   logic                   sck_rise, sck_fall;
   logic                   nss_s, nss_rise, nss_fall;
   logic [SYNC_STAGES-1:0] sdi_chain;
   logic                   sdi_s;
   logic [CW-1:0]          bit_cnt;
   logic [DATA_W-1:0]      rx_shift, tx_shift, tx_buf, next_word;
   logic                   tx_full, sdo_q, last_bit, consume;

   spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .nreset(nreset), .d(spi.sck),
      .q(unused_sck_level), .rise(sck_rise), .fall(sck_fall)
   );
   spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_nss (
      .clk(clk), .nreset(nreset), .d(spi.nss),
      .q(nss_s), .rise(nss_rise), .fall(nss_fall)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sdi_chain <= '0;
      else         sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], spi.sdi};
   end
   assign sdi_s = sdi_chain[SYNC_STAGES-1];

   // Buffer consumption happens at frame start and at every completed word,
   // so MISO for the next word is latched while the master idles between words.
   always_comb begin
      last_bit  = bit_cnt == CW'(DATA_W - 1);
      consume   = nss_fall || (!nss_s && !nss_rise && sck_rise && last_bit);
      next_word = tx_full ? tx_buf : DATA_W'(TX_FILL);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         tx_buf   <= '0;
         tx_full  <= 1'b0;
         sdo_q    <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         // a load beats a same-cycle consumption, which already used next_word
         if (tx_load && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end else if (consume) begin
            tx_full <= 1'b0;
         end
         if (nss_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            sdo_q    <= next_word[DATA_W-1];
            tx_shift <= next_word << 1;
         end else if (nss_rise) begin
            bit_cnt <= '0;
            sdo_q   <= 1'b0;
         end else if (!nss_s && sck_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], sdi_s};
            if (last_bit) begin
               bit_cnt  <= '0;
               rx_data  <= {rx_shift[DATA_W-2:0], sdi_s};
               rx_valid <= 1'b1;
               tx_shift <= next_word;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else if (!nss_s && sck_fall) begin
            sdo_q    <= tx_shift[DATA_W-1];
            tx_shift <= tx_shift << 1;
         end
      end
   end

   assign spi.sdo      = sdo_q;
   assign tx_ready     = ~tx_full;
   assign frame_active = ~nss_s;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: randomised self-checking bench for spi_slave_sync
module tb_spi_slave_sync;
   import spi_pkg::*;
   localparam int SS = 2;
   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       tx_ready;
   logic       frame_active;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] rx_q[$];
   logic [7:0] mq[$];
   logic [7:0] exp_miso = 8'h00;

   spi_slave_sync_if spi();

   spi_slave_sync #(.SYNC_STAGES(SS), .DATA_W(8)) dut (
      .clk(clk), .nreset(nreset), .spi(spi),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .frame_active(frame_active)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

   // one-deep transmit buffer: a word start takes the buffered word or TX_FILL
   function automatic logic [7:0] model_take();
      if (mq.size() != 0) return mq.pop_front();
      return TX_FILL;
   endfunction

   task automatic push(input logic [7:0] v);
      @(negedge clk);
      n_cmp++;
      if (tx_ready !== (mq.size() == 0)) begin
         n_bad++;
         $display("FAIL tx_ready_before_load: got %b expected %b", tx_ready, mq.size() == 0);
      end
      tx_data = v;
      tx_load = 1'b1;
      if (mq.size() == 0) mq.push_back(v);
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      spi.nss = 1'b0;
      repeat (8) @(negedge clk);
      exp_miso = model_take();
      n_cmp++;
      if (frame_active !== 1'b1 || tx_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL frame_start: frame_active=%b tx_ready=%b expected 1 1", frame_active, tx_ready);
      end
   endtask

   task automatic frame_end();
      repeat (4) @(negedge clk);
      spi.nss = 1'b1;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (frame_active !== 1'b0 || spi.sdo !== 1'b0) begin
         n_bad++;
         $display("FAIL frame_end: frame_active=%b sdo=%b expected 0 0", frame_active, spi.sdo);
      end
   endtask

   // clocks nbits of mosi out; optional tx_load lands in the cycle the last bit is consumed
   task automatic bits(input logic [7:0] mosi, input int nbits, input bit ld,
                       input logic [7:0] ldv, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi.sdi = mosi[7-i];
         repeat (8) @(negedge clk);
         miso = {miso[6:0], spi.sdo};
         spi.sck = 1'b1;
         n_cmp++;
         if (frame_active !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_active_bit%0d: got %b expected 1", i, frame_active);
         end
         if (i == 7 && ld) begin
            repeat (SS) @(negedge clk);
            tx_data = ldv;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            repeat (8 - SS - 1) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         spi.sck = 1'b0;
      end
   endtask

   task automatic word(input logic [7:0] mosi, input bit ld, input logic [7:0] ldv);
      logic [7:0] miso;
      bit         ready;
      bits(mosi, 8, ld, ldv, miso);
      n_cmp++;
      if (miso !== exp_miso) begin
         n_bad++;
         $display("FAIL miso_word: got %h expected %h", miso, exp_miso);
      end
      ready    = mq.size() == 0;
      exp_miso = model_take();
      if (ld && ready) mq.push_back(ldv);
      n_cmp++;
      if (rx_q.size() != 1 || rx_q[0] !== mosi) begin
         n_bad++;
         $display("FAIL rx_word: got %0d pulses first %h expected 1 pulse %h",
                  rx_q.size(), rx_q.size() ? rx_q[0] : 8'hxx, mosi);
      end
      rx_q.delete();
   endtask

   task automatic check_idle(input string tag);
      n_cmp++;
      if (spi.sdo !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b1 ||
          frame_active !== 1'b0 || rx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL %s: sdo=%b rx_valid=%b tx_ready=%b frame_active=%b rx_data=%h expected 0 0 1 0 00",
                  tag, spi.sdo, rx_valid, tx_ready, frame_active, rx_data);
      end
   endtask

   task automatic test_reset();
      logic [7:0] m;
      repeat (4) @(negedge clk);
      check_idle("reset_hold");
      nreset = 1'b1;
      push(8'h99);
      frame_start();
      push(8'h55);
      bits(8'hF0, 3, 1'b0, 8'h00, m);
      @(negedge clk);
      nreset = 1'b0;
      spi.nss = 1'b1;
      spi.sck = 1'b0;
      mq.delete();
      rx_q.delete();
      repeat (3) @(negedge clk);
      check_idle("reset_mid_frame");
      nreset = 1'b1;
      repeat (20) @(negedge clk);
      check_idle("reset_release");
      n_cmp++;
      if (rx_q.size() != 0) begin
         n_bad++;
         $display("FAIL reset_no_rx: got %0d pulses expected 0", rx_q.size());
      end
   endtask

   task automatic test_single();
      frame_start();
      word(8'hA5, 1'b0, 8'h00);
      frame_end();
   endtask

   task automatic test_full_duplex();
      push(8'h3C);
      n_cmp++;
      if (tx_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL tx_ready_after_load: got %b expected 0", tx_ready);
      end
      frame_start();
      word(8'h5A, 1'b0, 8'h00);
      frame_end();
   endtask

   task automatic test_back_to_back();
      frame_start();
      push(8'hC3);
      word(8'h12, 1'b0, 8'h00);
      word(8'h34, 1'b0, 8'h00);
      frame_end();
   endtask

   task automatic test_underrun();
      frame_start();
      word(8'h11, 1'b1, 8'h77);
      n_cmp++;
      if (tx_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL underrun_load_kept: tx_ready=%b expected 0", tx_ready);
      end
      word(8'h22, 1'b0, 8'h00);
      frame_end();
   endtask

   task automatic test_abort();
      logic [7:0] m;
      frame_start();
      bits(8'hFF, 5, 1'b0, 8'h00, m);
      frame_end();
      n_cmp++;
      if (rx_q.size() != 0) begin
         n_bad++;
         $display("FAIL abort_no_rx: got %0d pulses expected 0", rx_q.size());
      end
      rx_q.delete();
      frame_start();
      word(8'h81, 1'b0, 8'h00);
      frame_end();
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(1) == 1) push(8'($urandom_range(255)));
         frame_start();
         for (int w = 0; w < int'($urandom_range(3, 1)); w++) begin
            if ($urandom_range(1) == 1) push(8'($urandom_range(255)));
            word(8'($urandom_range(255)), $urandom_range(1) == 1, 8'($urandom_range(255)));
         end
         frame_end();
      end
   endtask

   initial begin
      spi.sck = 1'b0;
      spi.sdi = 1'b0;
      spi.nss = 1'b1;
      test_reset();
      test_single();
      test_full_duplex();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
